ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port synchronous main RAM between three requesters: CPU instruction fetch, CPU data load/store, and a program loader.
- The loader writes test/boot images into RAM while the CPU is held.
- In normal run, instruction and data ports are arbitrated round-robin.
- Sits between the core and ram_main inside top.

Parameters:
- ADDR_W, 12, word-address width of RAM and all requester address ports.
- DATA_W, 32, data word width; byte-enable width is DATA_W/8.
- BOOT_LOAD, 1, 1 = leave reset in LOAD state with CPU held; 0 = leave reset in RUN.

Ports:
- sys_clk  in  1  system clock, all state on rising edge
- sys_res  in  1  asynchronous, active-low reset
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_done  in  1  loader finished, single-cycle pulse
- ld_gnt  out  1  loader request accepted this cycle
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  RAM access enable
- mem_we  out  DATA_W/8  RAM byte write enables
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the enabled read
- cpu_hold  out  1  CPU must stall; high while in LOAD

Behaviour:
Handshake
- A requester holds req, addr and data stable until it samples gnt=1 on a rising edge.
- Grant is combinational in the same cycle; the RAM port is driven in that cycle.
- At most one gnt is high per cycle.

Read return
- i_rvalid / d_rvalid are registered and assert exactly 1 cycle after a granted read.
- i_rdata and d_rdata pass mem_rdata through directly; they are meaningful only when the matching rvalid is high.
- Writes never produce rvalid.
- Back-to-back reads are supported; throughput is 1 access per cycle.

FSM: RUN, LOAD
- Reset state is LOAD if BOOT_LOAD=1, otherwise RUN.
- cpu_hold = (state == LOAD).

LOAD state
- Only the loader is granted: ld_gnt = ld_req; i_gnt = d_gnt = 0.
- ld_done moves to RUN next cycle.
- ld_req and ld_done in the same cycle: the write is granted, then RUN.

RUN state
- ld_req has top priority: ld_gnt = 1, CPU grants are 0, and the next state is LOAD.
- Otherwise i_req / d_req are arbitrated round-robin using a 1-bit last-grant register.
- When both request, the port not granted last wins.
- A lone requester is always granted.
- The last-grant register updates only on an actual i/d grant.
- Reset value of last-grant is "data", so instruction wins the first conflict.
- ld_done in RUN is ignored.

RAM drive
- mem_en = any gnt.
- Loader: mem_we = all ones, mem_addr = ld_addr, mem_wdata = ld_wdata.
- Data store: mem_we = d_be.
- Any read: mem_we = 0.
- When idle, mem_we = 0 and mem_addr / mem_wdata are don't-care (drive 0).

Reset
- While sys_res is low, all gnt, rvalid and mem_en are forced to 0, and cpu_hold = BOOT_LOAD.
- Reset asserted mid-operation clears pending rvalid immediately; a read granted in the cycle before reset asserts never reports rvalid.

Test Plan:
1. Boot load:
   - Stimulus: BOOT_LOAD=1; release reset with i_req=1 held; loader writes addr 0..3 with 0x00000013, 0x00100093, 0x00200113, 0x002081B3; then pulse ld_done.
   - Required response: cpu_hold=1 and i_gnt=0 throughout; ld_gnt=1 on each write with mem_we=0xF; cycle after ld_done, cpu_hold=0 and i_gnt=1.
2. Round-robin conflict:
   - Stimulus: in RUN, i_req and d_req both held for 4 cycles.
   - Required response: grant order is i, d, i, d; each rvalid rises on its own port 1 cycle after its grant, with rdata = RAM content.
3. Byte store:
   - Stimulus: d_we=1, d_be=0b0010, d_wdata=0xAABBCCDD, d_addr=5 over word 0x11223344.
   - Required response: mem_we=0b0010; a subsequent load of addr 5 returns 0x1122CC44 with d_rvalid 1 cycle after d_gnt.
4. Loader preempt in RUN:
   - Stimulus: i_req and ld_req asserted in the same cycle.
   - Required response: ld_gnt=1, i_gnt=0; next cycle cpu_hold=1; i_gnt stays 0 until ld_done.
5. Reset mid-read:
   - Stimulus: grant a d read, then assert sys_res low before the next edge.
   - Required response: d_rvalid never asserts; after release, cpu_hold = BOOT_LOAD and all gnt=0 while reqs are low.
6. ld_done and ld_req in the same cycle in LOAD:
   - Required response: the write is performed (mem_en=1, mem_we=0xF), and the next cycle is in RUN.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles every requester and RAM-side signal of the main RAM arbiter.
//   ld_*      : program loader write port (request, address, data, done pulse, grant)
//   i_*       : CPU instruction fetch port (read only)
//   d_*       : CPU data load/store port with byte enables
//   mem_*     : single-port synchronous RAM drive and read data
//   cpu_hold  : CPU stall while the loader owns the RAM
// Modports: slave = the arbiter, master = requesters plus RAM.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_done;
    logic              ld_gnt;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              cpu_hold;

    modport slave (
        input  ld_req, ld_addr, ld_wdata, ld_done,
        output ld_gnt,
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output cpu_hold
    );

    modport master (
        output ld_req, ld_addr, ld_wdata, ld_done,
        input  ld_gnt,
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  cpu_hold
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single-port main RAM between the program loader, CPU instruction
// fetch and CPU data load/store. In LOAD only the loader is served and the CPU
// is held; in RUN a loader request preempts (and returns to LOAD), otherwise
// fetch and data are arbitrated round-robin. Grants are combinational and the
// RAM is driven in the grant cycle; read-valid flags follow one cycle later
// alongside the RAM's registered read data.
// Ports:
//   sys_clk : system clock, rising edge
//   sys_res : asynchronous active-low reset
//   bus     : ram_port_arbiter_if.slave (requester ports, RAM drive, cpu_hold)
module ram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_res,
    ram_port_arbiter_if.slave      bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam state_e RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

    state_e state_q, state_d;
    logic   last_is_d_q, last_is_d_d;   // 1 = data port won the last i/d grant
    logic   i_rvalid_q, i_rvalid_d;
    logic   d_rvalid_q, d_rvalid_d;

    logic   ld_gnt, i_gnt, d_gnt;

    // Arbitration and next state.
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        last_is_d_d = last_is_d_q;
        ld_gnt      = 1'b0;
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;

        // Grants are combinational, so they are masked directly by reset.
        if (sys_res) begin
            unique case (state_q)
                ST_LOAD: begin
                    ld_gnt = bus.ld_req;
                    if (bus.ld_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.ld_req) begin
                        ld_gnt  = 1'b1;
                        state_d = ST_LOAD;
                    end else if (bus.i_req && bus.d_req) begin
                        // Conflict: the port not served last time wins.
                        i_gnt = last_is_d_q;
                        d_gnt = !last_is_d_q;
                    end else begin
                        i_gnt = bus.i_req;
                        d_gnt = bus.d_req;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end

        if (i_gnt) begin
            last_is_d_d = 1'b0;
        end else if (d_gnt) begin
            last_is_d_d = 1'b1;
        end

        i_rvalid_d = i_gnt;
        d_rvalid_d = d_gnt && !bus.d_we;
    end

    // RAM drive: the granted requester owns the port this cycle.
    always_comb begin
        bus.mem_en    = ld_gnt || i_gnt || d_gnt;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (ld_gnt) begin
            bus.mem_we    = '1;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_wdata;
        end else if (d_gnt) begin
            bus.mem_we    = bus.d_we ? bus.d_be : '0;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            bus.mem_addr  = bus.i_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // Async reset drops rvalid immediately, so a read granted just before
    // reset never reports data.
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            state_q     <= RESET_STATE;
            last_is_d_q <= 1'b1;
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_is_d_q <= last_is_d_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign bus.ld_gnt   = ld_gnt;
    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;
    assign bus.cpu_hold = (state_q == ST_LOAD);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter (BOOT_LOAD=1) with a behavioural
// single-port RAM. Each table row is one clock cycle of requester inputs
// plus the hand-computed grants, RAM drive, cpu_hold and read returns.
module tb_ram_port_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int N_VEC  = 27;

    logic sys_clk = 1'b0;
    logic sys_res = 1'b0;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BOOT_LOAD(1'b1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_res(sys_res),
        .bus    (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural RAM: byte-write, read data registered one cycle later.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge sys_clk) begin
        if (bus.mem_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic        ld_req;
        logic        ld_done;
        logic [11:0] ld_addr;
        logic [31:0] ld_wdata;
        logic        i_req;
        logic [11:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [11:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_ld;
        logic        e_i;
        logic        e_d;
        logic [3:0]  e_we;
        logic [11:0] e_addr;
        logic        e_hold;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl [N_VEC];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.ld_req = 1'b0; bus.ld_done = 1'b0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " ld_gnt"}, bus.ld_gnt, 1'b0);
        check({tag, " i_gnt"},  bus.i_gnt,  1'b0);
        check({tag, " d_gnt"},  bus.d_gnt,  1'b0);
        check({tag, " mem_en"}, bus.mem_en, 1'b0);
    endtask

    initial begin
        //            ld_req done addr wdata          i_req addr  d_req we be     addr wdata           e_ld i d we     addr hold irv drv rdata
        // Boot load of addr 0..3 with the CPU fetch held off.
        tbl[0]  = '{1, 0, 0, 32'h00000013,  1, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 0, 1, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 1, 32'h00100093,  1, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 1, 1, 0, 0, 32'h0};
        tbl[2]  = '{1, 0, 2, 32'h00200113,  1, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 2, 1, 0, 0, 32'h0};
        tbl[3]  = '{1, 0, 3, 32'h002081B3,  1, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 3, 1, 0, 0, 32'h0};
        tbl[4]  = '{0, 1, 0, 32'h0,         1, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 1, 0, 0, 32'h0};
        tbl[5]  = '{0, 0, 0, 32'h0,         1, 0,  0, 0, 4'h0, 0, 32'h0,          0, 1, 0, 4'h0, 0, 0, 0, 0, 32'h0};
        // Lone data load, then four cycles of i/d conflict: i, d, i, d.
        tbl[6]  = '{0, 0, 0, 32'h0,         0, 0,  1, 0, 4'h0, 3, 32'h0,          0, 0, 1, 4'h0, 3, 0, 1, 0, 32'h00000013};
        tbl[7]  = '{0, 0, 0, 32'h0,         1, 1,  1, 0, 4'h0, 2, 32'h0,          0, 1, 0, 4'h0, 1, 0, 0, 1, 32'h002081B3};
        tbl[8]  = '{0, 0, 0, 32'h0,         1, 1,  1, 0, 4'h0, 2, 32'h0,          0, 0, 1, 4'h0, 2, 0, 1, 0, 32'h00100093};
        tbl[9]  = '{0, 0, 0, 32'h0,         1, 1,  1, 0, 4'h0, 2, 32'h0,          0, 1, 0, 4'h0, 1, 0, 0, 1, 32'h00200113};
        tbl[10] = '{0, 0, 0, 32'h0,         1, 1,  1, 0, 4'h0, 2, 32'h0,          0, 0, 1, 4'h0, 2, 0, 1, 0, 32'h00100093};
        // Full-word store, byte store into byte 1, load back.
        tbl[11] = '{0, 0, 0, 32'h0,         0, 0,  1, 1, 4'hF, 5, 32'h11223344,   0, 0, 1, 4'hF, 5, 0, 0, 1, 32'h00200113};
        tbl[12] = '{0, 0, 0, 32'h0,         0, 0,  1, 1, 4'h2, 5, 32'hAABBCCDD,   0, 0, 1, 4'h2, 5, 0, 0, 0, 32'h0};
        tbl[13] = '{0, 0, 0, 32'h0,         0, 0,  1, 0, 4'h0, 5, 32'h0,          0, 0, 1, 4'h0, 5, 0, 0, 0, 32'h0};
        tbl[14] = '{0, 0, 0, 32'h0,         0, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h1122CC44};
        // Loader preempts a fetch in RUN, CPU held until ld_done.
        tbl[15] = '{1, 0, 6, 32'hDEADBEEF,  1, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 6, 0, 0, 0, 32'h0};
        tbl[16] = '{0, 0, 0, 32'h0,         1, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 1, 0, 0, 32'h0};
        tbl[17] = '{0, 0, 0, 32'h0,         1, 0,  1, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 1, 0, 0, 32'h0};
        tbl[18] = '{0, 1, 0, 32'h0,         1, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 1, 0, 0, 32'h0};
        tbl[19] = '{0, 0, 0, 32'h0,         1, 6,  0, 0, 4'h0, 0, 32'h0,          0, 1, 0, 4'h0, 6, 0, 0, 0, 32'h0};
        tbl[20] = '{0, 0, 0, 32'h0,         0, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 0, 1, 0, 32'hDEADBEEF};
        // ld_done in RUN is ignored.
        tbl[21] = '{0, 1, 0, 32'h0,         0, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 0, 0, 0, 32'h0};
        tbl[22] = '{0, 0, 0, 32'h0,         0, 0,  1, 0, 4'h0, 0, 32'h0,          0, 0, 1, 4'h0, 0, 0, 0, 0, 32'h0};
        // Enter LOAD, then ld_req with ld_done: write done, back in RUN.
        tbl[23] = '{1, 0, 7, 32'h00000007,  0, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 7, 0, 0, 1, 32'h00000013};
        tbl[24] = '{1, 1, 8, 32'h00000088,  0, 0,  0, 0, 4'h0, 0, 32'h0,          1, 0, 0, 4'hF, 8, 1, 0, 0, 32'h0};
        tbl[25] = '{0, 0, 0, 32'h0,         1, 8,  0, 0, 4'h0, 0, 32'h0,          0, 1, 0, 4'h0, 8, 0, 0, 0, 32'h0};
        tbl[26] = '{0, 0, 0, 32'h0,         0, 0,  0, 0, 4'h0, 0, 32'h0,          0, 0, 0, 4'h0, 0, 0, 1, 0, 32'h00000088};

        // Reset held with requests pending: nothing may be granted.
        drive_idle();
        bus.ld_req = 1'b1;
        bus.i_req  = 1'b1;
        repeat (2) @(posedge sys_clk);
        #4;
        check_quiet("rst");
        check("rst cpu_hold", bus.cpu_hold, 1'b1);
        check("rst i_rvalid", bus.i_rvalid, 1'b0);
        check("rst d_rvalid", bus.d_rvalid, 1'b0);

        // Release with fetch still requested: LOAD holds the CPU.
        @(posedge sys_clk);
        #1;
        sys_res    = 1'b1;
        bus.ld_req = 1'b0;
        #3;
        check_quiet("rel");
        check("rel cpu_hold", bus.cpu_hold, 1'b1);

        for (int k = 0; k < N_VEC; k++) begin
            @(posedge sys_clk);
            #1;
            bus.ld_req   = tbl[k].ld_req;
            bus.ld_done  = tbl[k].ld_done;
            bus.ld_addr  = tbl[k].ld_addr;
            bus.ld_wdata = tbl[k].ld_wdata;
            bus.i_req    = tbl[k].i_req;
            bus.i_addr   = tbl[k].i_addr;
            bus.d_req    = tbl[k].d_req;
            bus.d_we     = tbl[k].d_we;
            bus.d_be     = tbl[k].d_be;
            bus.d_addr   = tbl[k].d_addr;
            bus.d_wdata  = tbl[k].d_wdata;
            #3;
            check($sformatf("v%0d ld_gnt", k),   bus.ld_gnt,   tbl[k].e_ld);
            check($sformatf("v%0d i_gnt", k),    bus.i_gnt,    tbl[k].e_i);
            check($sformatf("v%0d d_gnt", k),    bus.d_gnt,    tbl[k].e_d);
            check($sformatf("v%0d mem_en", k),   bus.mem_en,   tbl[k].e_ld | tbl[k].e_i | tbl[k].e_d);
            check($sformatf("v%0d mem_we", k),   bus.mem_we,   tbl[k].e_we);
            check($sformatf("v%0d mem_addr", k), bus.mem_addr, tbl[k].e_addr);
            check($sformatf("v%0d cpu_hold", k), bus.cpu_hold, tbl[k].e_hold);
            check($sformatf("v%0d i_rvalid", k), bus.i_rvalid, tbl[k].e_irv);
            check($sformatf("v%0d d_rvalid", k), bus.d_rvalid, tbl[k].e_drv);
            if (tbl[k].e_irv) check($sformatf("v%0d i_rdata", k), bus.i_rdata, tbl[k].e_rdata);
            if (tbl[k].e_drv) check($sformatf("v%0d d_rdata", k), bus.d_rdata, tbl[k].e_rdata);
        end

        // Reset mid-read: a granted load must never report rvalid.
        @(posedge sys_clk);
        #1;
        drive_idle();
        bus.d_req  = 1'b1;
        bus.d_addr = 12'd8;
        #3;
        check("mid d_gnt", bus.d_gnt, 1'b1);
        #2;
        sys_res    = 1'b0;
        bus.d_req  = 1'b0;
        bus.ld_req = 1'b1;
        bus.i_req  = 1'b1;
        #1;
        check("mid d_rvalid", bus.d_rvalid, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge sys_clk);
            #4;
            check($sformatf("mid%0d d_rvalid", c), bus.d_rvalid, 1'b0);
            check_quiet($sformatf("mid%0d", c));
        end

        // Release with requests low: back in LOAD, nothing granted.
        @(posedge sys_clk);
        #1;
        sys_res = 1'b1;
        drive_idle();
        #3;
        check_quiet("post");
        check("post cpu_hold", bus.cpu_hold, 1'b1);
        check("post d_rvalid", bus.d_rvalid, 1'b0);

        // Leave LOAD; the first conflict after reset goes to instruction.
        @(posedge sys_clk);
        #1;
        bus.ld_done = 1'b1;
        #3;
        check("done cpu_hold", bus.cpu_hold, 1'b1);
        @(posedge sys_clk);
        #1;
        bus.ld_done = 1'b0;
        bus.i_req   = 1'b1;
        bus.d_req   = 1'b1;
        #3;
        check("rr0 cpu_hold", bus.cpu_hold, 1'b0);
        check("rr0 i_gnt", bus.i_gnt, 1'b1);
        check("rr0 d_gnt", bus.d_gnt, 1'b0);
        @(posedge sys_clk);
        #1;
        drive_idle();
        @(posedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
